clock_set_ctrl: RTL and testbench

//  Button-driven time-set controller for the BCD clock datapath. Debounces MODE/INC buttons,

---
 rtl/clock_pkg.sv | 42 ++++
 rtl/btn_debounce.sv | 56 +++++
 rtl/clock_set_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_clock_set_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared definitions for the clock time-set path: FSM states, digit map,
// BCD field limits, per-state blink masks and the BCD field incrementer.
package clock_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_SET_HR  = 2'd1,
        ST_SET_MIN = 2'd2,
        ST_SET_SEC = 2'd3
    } state_e;

    // Digit positions as seen by the scanner; 2 and 5 are the separators.
    localparam int DIG_S0   = 0;
    localparam int DIG_S1   = 1;
    localparam int DIG_SEP0 = 2;
    localparam int DIG_M0   = 3;
    localparam int DIG_M1   = 4;
    localparam int DIG_SEP1 = 5;
    localparam int DIG_H0   = 6;
    localparam int DIG_H1   = 7;

    localparam logic [7:0] HR_MAX = 8'h23;
    localparam logic [7:0] MS_MAX = 8'h59;

    localparam logic [7:0] MASK_HR  = 8'((1 << DIG_H1) | (1 << DIG_H0));
    localparam logic [7:0] MASK_MIN = 8'((1 << DIG_M1) | (1 << DIG_M0));
    localparam logic [7:0] MASK_SEC = 8'((1 << DIG_S1) | (1 << DIG_S0));

    // Two-digit BCD +1 that wraps to 00 after max_v (full-byte compare).
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max_v);
        logic [7:0] r;
        if (v == max_v) begin
            r = 8'h00;
        end else if (v[3:0] == 4'd9) begin
            r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw button conditioner: 2-FF synchroniser, stability counter and a
// registered one-cycle press pulse on the debounced rising edge.
module btn_debounce #(
    parameter int DB_CYCLES = 640000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic level_o,
    output logic press_o
);

    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Counter only runs while the synchronised input disagrees with the
    // accepted level; any agreeing sample restarts the stability window.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        press_d = 1'b0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
                press_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = level_q;
    assign press_o = press_q;

endmodule

// File: rtl/clock_set_ctrl.sv
// Button-driven time-set controller: MODE steps through the fields, INC
// (with auto-repeat) edits a shadow copy, which is loaded back on exit.
//
//  state      | meaning
//  ST_RUN     | counter runs, no blinking, INC ignored
//  ST_SET_HR  | editing hours, H1/H0 blink
//  ST_SET_MIN | editing minutes, M1/M0 blink
//  ST_SET_SEC | editing seconds, S1/S0 blink; MODE loads edit back
module clock_set_ctrl
    import clock_pkg::*;
#(
    parameter int DB_CYCLES    = 640000,
    parameter int BLINK_DIV    = 8000000,
    parameter int REPEAT_DELAY = 16000000,
    parameter int REPEAT_RATE  = 4000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_mode,
    input  logic        btn_inc,
    input  logic [23:0] time_in,
    output logic        run_en,
    output logic        time_load,
    output logic [23:0] time_out,
    output logic [7:0]  blink_mask
);

    localparam int BW      = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW      = (REP_MAX > 1) ? $clog2(REP_MAX) : 1;

    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
    localparam logic [RW-1:0] REP_FIRST  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] REP_NEXT   = RW'(REPEAT_RATE - 1);

    logic mode_level, mode_press;
    logic inc_level, inc_press;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_mode (
        .clk     (clk),
        .rst     (rst),
        .btn_i   (btn_mode),
        .level_o (mode_level),
        .press_o (mode_press)
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_inc (
        .clk     (clk),
        .rst     (rst),
        .btn_i   (btn_inc),
        .level_o (inc_level),
        .press_o (inc_press)
    );

    state_e        state_q, state_d;
    logic [23:0]   edit_q, edit_d;
    logic [23:0]   time_out_q, time_out_d;
    logic          load_q, load_d;
    logic          run_en_q, run_en_d;
    logic [7:0]    mask_q, mask_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          phase_q, phase_d;
    logic [RW-1:0] rep_cnt_q, rep_cnt_d;
    logic          rep_pulse;
    logic          inc_evt;

    // Auto-repeat: the press pulse arms the delay; the down-counter then
    // reloads with the repeat rate on every terminal count while held.
    always_comb begin
        rep_cnt_d = rep_cnt_q;
        rep_pulse = 1'b0;
        if (inc_press) begin
            rep_cnt_d = REP_FIRST;
        end else if (!inc_level) begin
            rep_cnt_d = '0;
        end else if (rep_cnt_q == '0) begin
            rep_pulse = 1'b1;
            rep_cnt_d = REP_NEXT;
        end else begin
            rep_cnt_d = rep_cnt_q - 1'b1;
        end
    end

    assign inc_evt = inc_press | rep_pulse;

    // MODE is tested first in every state so a coincident INC is dropped.
    always_comb begin
        state_d    = state_q;
        edit_d     = edit_q;
        load_d     = 1'b0;
        time_out_d = time_out_q;
        case (state_q)
            ST_RUN: begin
                if (mode_press) begin
                    state_d = ST_SET_HR;
                    edit_d  = time_in;
                end
            end
            ST_SET_HR: begin
                if (mode_press) begin
                    state_d = ST_SET_MIN;
                end else if (inc_evt) begin
                    edit_d[23:16] = bcd_inc(edit_q[23:16], HR_MAX);
                end
            end
            ST_SET_MIN: begin
                if (mode_press) begin
                    state_d = ST_SET_SEC;
                end else if (inc_evt) begin
                    edit_d[15:8] = bcd_inc(edit_q[15:8], MS_MAX);
                end
            end
            ST_SET_SEC: begin
                if (mode_press) begin
                    state_d    = ST_RUN;
                    load_d     = 1'b1;
                    time_out_d = edit_q;
                end else if (inc_evt) begin
                    edit_d[7:0] = bcd_inc(edit_q[7:0], MS_MAX);
                end
            end
            default: state_d = ST_RUN;
        endcase
        // Counter stays frozen through the load cycle and resumes after it.
        run_en_d = (state_d == ST_RUN) && !load_d;
    end

    always_comb begin
        blink_cnt_d = blink_cnt_q + 1'b1;
        phase_d     = phase_q;
        if (state_d != state_q) begin
            blink_cnt_d = '0;
            phase_d     = 1'b0;
        end else if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
        end
    end

    always_comb begin
        mask_d = 8'h00;
        if (phase_q && !inc_level) begin
            case (state_q)
                ST_SET_HR:  mask_d = MASK_HR;
                ST_SET_MIN: mask_d = MASK_MIN;
                ST_SET_SEC: mask_d = MASK_SEC;
                default:    mask_d = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_RUN;
            edit_q      <= '0;
            time_out_q  <= '0;
            load_q      <= 1'b0;
            run_en_q    <= 1'b1;
            mask_q      <= '0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
            rep_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            edit_q      <= edit_d;
            time_out_q  <= time_out_d;
            load_q      <= load_d;
            run_en_q    <= run_en_d;
            mask_q      <= mask_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            rep_cnt_q   <= rep_cnt_d;
        end
    end

    assign run_en     = run_en_q;
    assign time_load  = load_q;
    assign time_out   = time_out_q;
    assign blink_mask = mask_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl; loads are checked against a queue of
// expected time values pushed when the exiting MODE press is driven.
module tb_clock_set_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        btn_mode = 1'b0;
    logic        btn_inc = 1'b0;
    logic [23:0] time_in = 24'h0;
    logic        run_en;
    logic        time_load;
    logic [23:0] time_out;
    logic [7:0]  blink_mask;

    int          n_cmp = 0;
    int          n_err = 0;
    int          n_loads = 0;
    logic [23:0] sb[$];
    logic        chk_next = 1'b0;

    logic [7:0]  acc;
    logic [7:0]  prev_m;
    logic        rune_acc;
    int          last_chg, n_chg, bad;

    clock_set_ctrl #(
        .DB_CYCLES    (4),
        .BLINK_DIV    (8),
        .REPEAT_DELAY (32),
        .REPEAT_RATE  (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_mode   (btn_mode),
        .btn_inc    (btn_inc),
        .time_in    (time_in),
        .run_en     (run_en),
        .time_load  (time_load),
        .time_out   (time_out),
        .blink_mask (blink_mask)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_mode();
        btn_mode = 1'b1;
        tick(10);
        btn_mode = 1'b0;
        tick(10);
    endtask

    task automatic press_inc();
        btn_inc = 1'b1;
        tick(10);
        btn_inc = 1'b0;
        tick(10);
    endtask

    // Over 20 cycles the mask must show exactly the given pattern (or 0).
    task automatic expect_mask(input string tag, input logic [7:0] m);
        logic [7:0] a;
        a = 8'h00;
        for (int i = 0; i < 20; i++) begin
            a |= blink_mask;
            tick(1);
        end
        chk(tag, 32'(a), 32'(m));
    endtask

    always @(negedge clk) begin
        logic [23:0] exp_t;
        if (chk_next) begin
            chk("run_en_after_load", 32'(run_en), 32'd1);
            chk("load_one_cycle", 32'(time_load), 32'd0);
            chk_next = 1'b0;
        end
        if (time_load === 1'b1) begin
            n_loads++;
            exp_t = 24'hxxxxxx;
            if (sb.size() != 0) exp_t = sb.pop_front();
            chk("load_time_out", 32'(time_out), 32'(exp_t));
            chk("run_en_during_load", 32'(run_en), 32'd0);
            chk_next = 1'b1;
        end
    end

    initial begin
        // reset values
        tick(3);
        chk("rst_run_en", 32'(run_en), 32'd1);
        chk("rst_time_load", 32'(time_load), 32'd0);
        chk("rst_time_out", 32'(time_out), 32'd0);
        chk("rst_blink_mask", 32'(blink_mask), 32'd0);
        rst = 1'b0;
        tick(3);

        // bounce on MODE, then a clean hold
        time_in = 24'h23_59_58;
        rune_acc = 1'b1;
        for (int i = 0; i < 10; i++) begin
            btn_mode = ~btn_mode;
            tick(1);
            rune_acc &= run_en;
            tick(1);
            rune_acc &= run_en;
        end
        chk("bounce_no_press", 32'(rune_acc), 32'd1);
        btn_mode = 1'b1;
        tick(10);
        chk("bounce_run_en_off", 32'(run_en), 32'd0);
        expect_mask("bounce_single_press_hr", 8'hC0);
        btn_mode = 1'b0;
        tick(10);

        // full edit 23:59:58 -> 00:01:58
        time_in = 24'h11_11_11;
        press_inc();
        expect_mask("edit_state_hr", 8'hC0);
        press_mode();
        expect_mask("edit_state_min", 8'h18);
        press_inc();
        press_inc();
        press_mode();
        expect_mask("edit_state_sec", 8'h03);
        chk("edit_frozen", 32'(run_en), 32'd0);
        sb.push_back(24'h00_01_58);
        press_mode();
        tick(5);
        chk("edit_back_run", 32'(run_en), 32'd1);

        // seconds wrap 59 -> 00
        time_in = 24'h12_34_59;
        press_mode();
        press_mode();
        press_mode();
        press_inc();
        sb.push_back(24'h12_34_00);
        press_mode();
        tick(5);

        // hours 09 -> 10
        time_in = 24'h09_00_00;
        press_mode();
        press_inc();
        press_mode();
        press_mode();
        sb.push_back(24'h10_00_00);
        press_mode();
        tick(5);

        // auto-repeat in SET_MIN from 58
        time_in = 24'h00_58_00;
        press_mode();
        press_mode();
        expect_mask("rep_state_min", 8'h18);
        btn_inc = 1'b1;
        acc = 8'h00;
        for (int i = 1; i <= 70; i++) begin
            tick(1);
            if (i >= 8) acc |= blink_mask;
        end
        btn_inc = 1'b0;
        chk("rep_mask_held_zero", 32'(acc), 32'd0);
        tick(12);
        prev_m = blink_mask;
        last_chg = -1;
        n_chg = 0;
        bad = 0;
        for (int i = 0; i < 48; i++) begin
            tick(1);
            if (blink_mask !== 8'h00 && blink_mask !== 8'h18) bad++;
            if (blink_mask !== prev_m) begin
                if (last_chg >= 0 && (i - last_chg) != 8) bad++;
                last_chg = i;
                n_chg++;
            end
            prev_m = blink_mask;
        end
        chk("blink_pattern", 32'(bad), 32'd0);
        chk("blink_toggles", 32'(n_chg >= 4), 32'd1);
        press_mode();
        sb.push_back(24'h00_04_00);
        press_mode();
        tick(5);

        // simultaneous MODE + INC in SET_HR
        time_in = 24'h07_00_00;
        press_mode();
        btn_mode = 1'b1;
        btn_inc = 1'b1;
        tick(10);
        btn_mode = 1'b0;
        btn_inc = 1'b0;
        tick(10);
        expect_mask("simul_state_min", 8'h18);
        press_mode();
        sb.push_back(24'h07_00_00);
        press_mode();
        tick(5);

        // reset in the middle of an edit
        time_in = 24'h05_05_05;
        press_mode();
        press_mode();
        press_inc();
        chk("pre_rst_frozen", 32'(run_en), 32'd0);
        rst = 1'b1;
        tick(1);
        chk("mid_rst_run_en", 32'(run_en), 32'd1);
        chk("mid_rst_mask", 32'(blink_mask), 32'd0);
        chk("mid_rst_load", 32'(time_load), 32'd0);
        rst = 1'b0;
        tick(60);
        chk("post_rst_run_en", 32'(run_en), 32'd1);
        chk("post_rst_mask", 32'(blink_mask), 32'd0);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        chk("load_count", 32'(n_loads), 32'd5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
